// File: rtl/pvr_pcache_pkg.sv
// Shared constants, field layout and state encoding for the primitive cache loader.
package pvr_pcache_pkg;
   localparam int ENTRIES = 512;
   localparam int TAG_W   = 12;
   localparam int CNT_W   = 10;
   localparam int WORDS   = 24;

   localparam logic [4:0] F_ISP = 5'd0;
   localparam logic [4:0] F_TSP = 5'd1;
   localparam logic [4:0] F_TCW = 5'd2;

   localparam logic [2:0] V_X    = 3'd0;
   localparam logic [2:0] V_Y    = 3'd1;
   localparam logic [2:0] V_Z    = 3'd2;
   localparam logic [2:0] V_U0   = 3'd3;
   localparam logic [2:0] V_V0   = 3'd4;
   localparam logic [2:0] V_BASE = 3'd5;
   localparam logic [2:0] V_OFF  = 3'd6;

   localparam int ISP_TEX  = 25;
   localparam int ISP_OFFS = 24;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_VERT, S_COMMIT} state_t;

   // Record word index of field f of vertex v (A=0, B=1, C=2).
   function automatic logic [4:0] field_idx(input logic [1:0] v, input logic [2:0] f);
      return 5'd3 + 5'd7 * {3'b000, v} + {2'b00, f};
   endfunction
endpackage

// File: rtl/pcache_tag_alloc.sv
// Write-tag generator with wrap, plus the live-tag credit counter.
module pcache_tag_alloc
   import pvr_pcache_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             frame_reset,
   input  logic             alloc,
   input  logic             release_tag,
   output logic             full,
   output logic [TAG_W-1:0] tag,
   output logic [CNT_W-1:0] count,
   output logic             release_err
);
   logic [TAG_W-1:0] tag_reg;
   logic [CNT_W-1:0] count_reg;
   logic             rel_ok;

   // A release with nothing live is discarded and flagged upstream.
   assign rel_ok      = release_tag && (count_reg != '0);
   assign release_err = release_tag && (count_reg == '0);
   assign full        = (count_reg == CNT_W'(ENTRIES));
   assign tag         = tag_reg;
   assign count       = count_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_reg   <= '0;
         count_reg <= '0;
      end else if (frame_reset) begin
         tag_reg   <= '0;
         count_reg <= '0;
      end else begin
         if (alloc)
            tag_reg <= (tag_reg == TAG_W'(ENTRIES - 1)) ? '0 : tag_reg + 1'b1;
         if (alloc && !rel_ok)
            count_reg <= count_reg + 1'b1;
         else if (!alloc && rel_ok)
            count_reg <= count_reg - 1'b1;
      end
   end
endmodule

// File: rtl/pcache_prim_loader.sv
// Assembles 24-word triangle records from the parameter stream, writes them to the
// primitive cache under a freshly allocated tag and offers that tag to the ISP queue.
module pcache_prim_loader
   import pvr_pcache_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  frame_reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sop,
   input  logic [31:0]           in_data,
   output logic [TAG_W-1:0]      prim_tag,
   output logic                  pcache_write,
   output logic [32*WORDS-1:0]   pcache_rec,
   output logic                  tag_valid,
   input  logic                  tag_ready,
   output logic [TAG_W-1:0]      tag_out,
   input  logic                  tag_release,
   output logic [CNT_W-1:0]      tags_in_use,
   output logic                  err_sticky
);
   state_t           state_reg, state_next;
   logic [1:0]       vtx_reg, vtx_next;
   logic [2:0]       fld_reg, fld_next;
   logic             tex_reg, tex_next, offs_reg, offs_next;
   logic             pending_reg, pending_next;
   logic             in_ready_reg, write_reg, tag_valid_reg, err_reg;
   logic [TAG_W-1:0] prim_tag_reg, tag_out_reg, wr_tag;
   logic [31:0]      stage_reg [WORDS];
   logic [31:0]      rec_reg   [WORDS];

   logic       accept, can_fire, fire, store, clear, err_set, full, rel_err;
   logic       last_word, vertex_end;
   logic [4:0] store_idx;

   pcache_tag_alloc u_alloc (
      .clock       (clock),
      .reset_n     (reset_n),
      .frame_reset (frame_reset),
      .alloc       (fire),
      .release_tag (tag_release),
      .full        (full),
      .tag         (wr_tag),
      .count       (tags_in_use),
      .release_err (rel_err)
   );

   assign accept   = in_valid && in_ready_reg;
   assign can_fire = !full && (!tag_valid_reg || tag_ready);

   always_comb begin
      state_next   = state_reg;
      vtx_next     = vtx_reg;
      fld_next     = fld_reg;
      tex_next     = tex_reg;
      offs_next    = offs_reg;
      pending_next = pending_reg;
      fire         = 1'b0;
      store        = 1'b0;
      clear        = 1'b0;
      store_idx    = F_ISP;
      err_set      = rel_err;
      last_word    = 1'b0;
      vertex_end   = 1'b0;
      // Any accepted SOP word restarts assembly; mid-record it also flags an error.
      if (accept && in_sop && state_reg != S_COMMIT) begin
         clear      = 1'b1;
         store      = 1'b1;
         store_idx  = F_ISP;
         tex_next   = in_data[ISP_TEX];
         offs_next  = in_data[ISP_OFFS];
         fld_next   = 3'(F_TSP);
         state_next = S_HDR;
         if (state_reg != S_IDLE)
            err_set = 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept)
                  err_set = 1'b1;
            end
            S_HDR: begin
               if (accept) begin
                  store     = 1'b1;
                  store_idx = {2'b00, fld_reg};
                  if ({2'b00, fld_reg} == F_TCW) begin
                     state_next = S_VERT;
                     vtx_next   = 2'd0;
                     fld_next   = V_X;
                  end else begin
                     fld_next = 3'(F_TCW);
                  end
               end
            end
            S_VERT: begin
               if (accept) begin
                  store     = 1'b1;
                  store_idx = field_idx(vtx_reg, fld_reg);
                  case (fld_reg)
                     V_Z:     fld_next = tex_reg ? V_U0 : V_BASE;
                     V_BASE:  if (offs_reg) fld_next = V_OFF; else vertex_end = 1'b1;
                     V_OFF:   vertex_end = 1'b1;
                     default: fld_next = fld_reg + 3'd1;
                  endcase
                  if (vertex_end) begin
                     if (vtx_reg == 2'd2) begin
                        last_word = 1'b1;
                     end else begin
                        vtx_next = vtx_reg + 2'd1;
                        fld_next = V_X;
                     end
                  end
                  if (last_word) begin
                     state_next   = S_COMMIT;
                     fire         = can_fire;
                     pending_next = !can_fire;
                  end
               end
            end
            S_COMMIT: begin
               if (!pending_reg) begin
                  state_next = S_IDLE;
               end else if (can_fire) begin
                  fire         = 1'b1;
                  pending_next = 1'b0;
                  state_next   = S_IDLE;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         vtx_reg       <= '0;
         fld_reg       <= '0;
         tex_reg       <= 1'b0;
         offs_reg      <= 1'b0;
         pending_reg   <= 1'b0;
         in_ready_reg  <= 1'b0;
         write_reg     <= 1'b0;
         tag_valid_reg <= 1'b0;
         prim_tag_reg  <= '0;
         tag_out_reg   <= '0;
         err_reg       <= 1'b0;
      end else if (frame_reset) begin
         state_reg     <= S_IDLE;
         vtx_reg       <= '0;
         fld_reg       <= '0;
         tex_reg       <= 1'b0;
         offs_reg      <= 1'b0;
         pending_reg   <= 1'b0;
         in_ready_reg  <= 1'b0;
         write_reg     <= 1'b0;
         tag_valid_reg <= 1'b0;
         prim_tag_reg  <= '0;
         tag_out_reg   <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         vtx_reg      <= vtx_next;
         fld_reg      <= fld_next;
         tex_reg      <= tex_next;
         offs_reg     <= offs_next;
         pending_reg  <= pending_next;
         in_ready_reg <= (state_next != S_COMMIT);
         write_reg    <= fire;
         if (fire) begin
            prim_tag_reg  <= wr_tag;
            tag_out_reg   <= wr_tag;
            tag_valid_reg <= 1'b1;
         end else if (tag_ready) begin
            tag_valid_reg <= 1'b0;
         end
         if (err_set)
            err_reg <= 1'b1;
      end
   end

   // Assembly happens in a staging copy so the published record stays put while its tag is live.
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            stage_reg[gi] <= '0;
            rec_reg[gi]   <= '0;
         end else if (frame_reset) begin
            stage_reg[gi] <= '0;
            rec_reg[gi]   <= '0;
         end else begin
            if (store && store_idx == 5'(gi))
               stage_reg[gi] <= in_data;
            else if (clear)
               stage_reg[gi] <= '0;
            if (fire)
               rec_reg[gi] <= (store && store_idx == 5'(gi)) ? in_data : stage_reg[gi];
         end
      end
      assign pcache_rec[32*gi +: 32] = rec_reg[gi];
   end

   assign in_ready     = in_ready_reg;
   assign pcache_write = write_reg;
   assign tag_valid    = tag_valid_reg;
   assign prim_tag     = prim_tag_reg;
   assign tag_out      = tag_out_reg;
   assign err_sticky   = err_reg;
endmodule

// File: tb/tb_pcache_prim_loader.sv
// Directed self-checking bench for pcache_prim_loader.
module tb_pcache_prim_loader;
   import pvr_pcache_pkg::*;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          frame_reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sop = 1'b0;
   logic [31:0]   in_data = '0;
   logic          tag_ready = 1'b1;
   logic          tag_release = 1'b0;
   logic          in_ready, pcache_write, tag_valid, err_sticky;
   logic [11:0]   prim_tag, tag_out;
   logic [767:0]  pcache_rec;
   logic [9:0]    tags_in_use;

   pcache_prim_loader dut (
      .clock(clock), .reset_n(reset_n), .frame_reset(frame_reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_data(in_data),
      .prim_tag(prim_tag), .pcache_write(pcache_write), .pcache_rec(pcache_rec),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_out(tag_out),
      .tag_release(tag_release), .tags_in_use(tags_in_use), .err_sticky(err_sticky)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int           n_checks = 0;
   int           n_fail = 0;
   int           wr_count = 0;
   int           wr_cyc = 0;
   int           acc_cyc = 0;
   logic [11:0]  wr_tag_seen = '0;
   logic [767:0] wr_rec = '0;
   logic [11:0]  exp_tag = '0;

   task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // Every write must carry the next tag in allocation order.
   always @(negedge clock) begin
      if (pcache_write) begin
         wr_count++;
         wr_cyc      = cyc;
         wr_tag_seen = prim_tag;
         wr_rec      = pcache_rec;
         check("write_tag_seq", 768'(prim_tag), 768'(exp_tag));
         check("tag_out_at_write", 768'(tag_out), 768'(exp_tag));
         exp_tag = (exp_tag == 12'd511) ? 12'd0 : exp_tag + 12'd1;
      end
   end

   function automatic logic [31:0] wd(input logic [767:0] r, input int k);
      return r[32*k +: 32];
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic sop);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = sop;
      @(negedge clock);
      while (!in_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 768'(0), 768'(1));
      acc_cyc = cyc;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
   endtask

   // Expected record: words in stream order into the fixed 24-word layout, absent fields zero.
   task automatic send_rec(input logic [31:0] isp, input logic [31:0] base, output logic [767:0] exp);
      logic [31:0] w;
      exp = '0;
      send_word(isp, 1'b1);
      exp[31:0] = isp;
      send_word(base + 32'd1, 1'b0);
      exp[63:32] = base + 32'd1;
      send_word(base + 32'd2, 1'b0);
      exp[95:64] = base + 32'd2;
      w = base + 32'd3;
      for (int v = 0; v < 3; v++) begin
         for (int f = 0; f < 7; f++) begin
            if ((f == 3 || f == 4) && !isp[25]) continue;
            if (f == 6 && !isp[24]) continue;
            send_word(w, 1'b0);
            exp[32*(3 + 7*v + f) +: 32] = w;
            w = w + 32'd1;
         end
      end
   endtask

   task automatic wait_write(input int n0, input string tag);
      int t = 0;
      while (wr_count == n0 && t < 100) begin
         tick(1);
         t++;
      end
      check(tag, 768'(wr_count > n0), 768'(1));
   endtask

   task automatic pulse_release();
      tag_release = 1'b1;
      tick(1);
      tag_release = 1'b0;
   endtask

   task automatic do_frame_reset();
      frame_reset = 1'b1;
      tick(1);
      frame_reset = 1'b0;
      exp_tag = '0;
      tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [767:0] e, e2;
      int n0;

      tick(2);
      check("rst_in_ready", 768'(in_ready), 768'(0));
      check("rst_tag_valid", 768'(tag_valid), 768'(0));
      check("rst_write", 768'(pcache_write), 768'(0));
      check("rst_count", 768'(tags_in_use), 768'(0));
      check("rst_err", 768'(err_sticky), 768'(0));
      check("rst_rec", pcache_rec, 768'(0));
      reset_n = 1'b1;
      tick(2);

      // Untextured, no offset colour.
      n0 = wr_count;
      send_rec(32'h0000_0000, 32'h10, e);
      check("commit_in_ready", 768'(in_ready), 768'(0));
      wait_write(n0, "untex_write_seen");
      check("untex_one_write", 768'(wr_count), 768'(n0 + 1));
      check("untex_tag", 768'(wr_tag_seen), 768'(0));
      check("untex_latency", 768'(wr_cyc), 768'(acc_cyc + 1));
      check("untex_rec", wr_rec, e);
      check("untex_base_a", 768'(wd(wr_rec, 8)), 768'(32'h16));
      check("untex_u0_a", 768'(wd(wr_rec, 6)), 768'(0));
      check("untex_off_b", 768'(wd(wr_rec, 16)), 768'(0));
      check("untex_base_c", 768'(wd(wr_rec, 22)), 768'(32'h1E));
      check("untex_err", 768'(err_sticky), 768'(0));

      // Textured with offset colour: every field present, so word k carries base+k.
      n0 = wr_count;
      send_rec(32'h0300_0000, 32'h100, e);
      wait_write(n0, "tex_write_seen");
      check("tex_tag", 768'(wr_tag_seen), 768'(1));
      check("tex_rec", wr_rec, e);
      check("tex_v0_a", 768'(wd(wr_rec, 7)), 768'(32'h107));
      check("tex_off_c", 768'(wd(wr_rec, 23)), 768'(32'h117));
      check("tex_count", 768'(tags_in_use), 768'(2));

      // Credit release, then a release with nothing live.
      pulse_release();
      pulse_release();
      check("release_to_zero", 768'(tags_in_use), 768'(0));
      check("release_no_err", 768'(err_sticky), 768'(0));
      pulse_release();
      check("release_at_zero_count", 768'(tags_in_use), 768'(0));
      check("release_at_zero_err", 768'(err_sticky), 768'(1));
      do_frame_reset();
      check("frame_reset_err", 768'(err_sticky), 768'(0));
      check("frame_reset_tag_out", 768'(tag_out), 768'(0));

      // ISP queue back-pressure: second record must wait for tag 0 to be taken.
      tag_ready = 1'b0;
      n0 = wr_count;
      send_rec(32'h0000_0000, 32'h200, e);
      wait_write(n0, "bp_first_write");
      n0 = wr_count;
      send_rec(32'h0100_0000, 32'h300, e2);
      tick(4);
      check("bp_no_write", 768'(wr_count), 768'(n0));
      check("bp_stall_ready", 768'(in_ready), 768'(0));
      check("bp_tag_held_valid", 768'(tag_valid), 768'(1));
      check("bp_tag_held_value", 768'(tag_out), 768'(0));
      tag_ready = 1'b1;
      wait_write(n0, "bp_release_write");
      check("bp_second_rec", wr_rec, e2);
      check("bp_new_tag_out", 768'(tag_out), 768'(1));
      tick(2);
      check("bp_tag_valid_drop", 768'(tag_valid), 768'(0));

      // SOP in the middle of vertex B aborts and restarts.
      check("abort_pre_err", 768'(err_sticky), 768'(0));
      n0 = wr_count;
      send_word(32'h0000_0000, 1'b1);
      for (int i = 1; i < 9; i++) send_word(32'h500 + 32'(i), 1'b0);
      send_rec(32'h0000_0000, 32'h600, e);
      wait_write(n0, "abort_write_seen");
      tick(2);
      check("abort_err", 768'(err_sticky), 768'(1));
      check("abort_single_write", 768'(wr_count), 768'(n0 + 1));
      check("abort_tag", 768'(wr_tag_seen), 768'(2));
      check("abort_rec", wr_rec, e);

      // Exhaustion: fill all 512 entries, the next record waits for a release.
      do_frame_reset();
      n0 = wr_count;
      for (int i = 0; i < 512; i++) send_rec(32'h0000_0000, 32'(i) << 8, e);
      tick(3);
      check("full_writes", 768'(wr_count), 768'(n0 + 512));
      check("full_count", 768'(tags_in_use), 768'(512));
      n0 = wr_count;
      send_rec(32'h0000_0000, 32'hABC00, e);
      tick(5);
      check("full_stall_no_write", 768'(wr_count), 768'(n0));
      check("full_stall_ready", 768'(in_ready), 768'(0));
      check("full_stall_count", 768'(tags_in_use), 768'(512));
      pulse_release();
      check("full_no_same_cycle_fire", 768'(wr_count), 768'(n0));
      wait_write(n0, "full_release_write");
      check("full_wrap_tag", 768'(wr_tag_seen), 768'(0));
      check("full_wrap_rec", wr_rec, e);
      tick(2);
      check("full_count_after", 768'(tags_in_use), 768'(512));

      // Async reset mid-record with a tag still offered.
      pulse_release();
      tag_ready = 1'b0;
      n0 = wr_count;
      send_rec(32'h0000_0000, 32'h700, e);
      wait_write(n0, "arst_setup_write");
      for (int i = 0; i < 5; i++) send_word(32'h800 + 32'(i), i == 0);
      check("arst_pre_tag_valid", 768'(tag_valid), 768'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_tag_valid", 768'(tag_valid), 768'(0));
      check("arst_in_ready", 768'(in_ready), 768'(0));
      check("arst_count", 768'(tags_in_use), 768'(0));
      check("arst_tags", 768'({prim_tag, tag_out}), 768'(0));
      check("arst_rec", pcache_rec, 768'(0));
      exp_tag = '0;
      tick(2);
      reset_n = 1'b1;
      tag_ready = 1'b1;
      tick(1);
      n0 = wr_count;
      send_rec(32'h0000_0000, 32'h900, e);
      wait_write(n0, "arst_after_write");
      check("arst_after_tag", 768'(wr_tag_seen), 768'(0));
      check("arst_after_rec", wr_rec, e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
